// File: rtl/a_join_buf_pkg.sv
// Shared definitions for the asynchronous handshake join buffer: combine opcodes and FSM states.
// Purely declarative; no timing or flow-control behaviour lives here.
// Imported by the join logic and the output sequencer.
package a_join_buf_pkg;

  localparam int OP_XOR = 0;
  localparam int OP_AND = 1;
  localparam int OP_OR  = 2;
  localparam int OP_ADD = 3;

  typedef enum logic [1:0] {
    WAIT,
    HELD,
    ACKD
  } ch_state_t;

  typedef enum logic [1:0] {
    O_IDLE,
    O_SETUP,
    O_REQ,
    O_REL
  } out_state_t;

endpackage

// File: rtl/a_join_buf_hs_fifo.sv
// hs_fifo: small FIFO holding joined words between the input join and the output sequencer.
// Latency: a pushed word is visible on head the cycle after the push edge.
// Backpressure: a push while full is dropped even if a pop happens on the same edge.
module hs_fifo #(
  parameter int N     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [N-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/a_join_buf.sv
// Joins C four-phase bundled-data channels into one combined word, buffers it, and replays it four-phase.
// Latency: 4 clk edges from last in_r rise to in_a rise; out_r rises 1 cycle after out_d loads.
// Backpressure: with the buffer full all channels park in HELD with in_a low until a pop frees space.
module a_join_buf
  import a_join_buf_pkg::*;
#(
  parameter int C     = 2,
  parameter int N     = 6,
  parameter int DEPTH = 4,
  parameter int OP    = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [C-1:0]   in_r,
  output logic [C-1:0]   in_a,
  input  logic [C*N-1:0] in_d,
  output logic           out_r,
  input  logic           out_a,
  output logic [N-1:0]   out_d
);

  logic [C-1:0] in_r_s1_q;
  logic [C-1:0] in_r_s2_q;
  logic         out_a_s1_q;
  logic         out_a_s2_q;

  ch_state_t    ch_q   [C];
  logic [N-1:0] data_q [C];
  logic [C-1:0] in_a_q;

  out_state_t   ost_q;
  logic         out_r_q;
  logic [N-1:0] out_d_q;

  logic         all_held;
  logic         join_fire;
  logic [N-1:0] join_d;
  logic         fifo_full;
  logic         fifo_empty;
  logic [N-1:0] fifo_head;
  logic         pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_r_s1_q  <= '0;
      in_r_s2_q  <= '0;
      out_a_s1_q <= 1'b0;
      out_a_s2_q <= 1'b0;
    end else begin
      in_r_s1_q  <= in_r;
      in_r_s2_q  <= in_r_s1_q;
      out_a_s1_q <= out_a;
      out_a_s2_q <= out_a_s1_q;
    end
  end

  always_comb begin
    all_held = 1'b1;
    for (int k = 0; k < C; k++) begin
      if (ch_q[k] != HELD) all_held = 1'b0;
    end
  end

  assign join_fire = all_held && !fifo_full;

  always_comb begin
    join_d = data_q[0];
    for (int k = 1; k < C; k++) begin
      case (OP)
        OP_AND:  join_d = join_d & data_q[k];
        OP_OR:   join_d = join_d | data_q[k];
        OP_ADD:  join_d = join_d + data_q[k];
        default: join_d = join_d ^ data_q[k];
      endcase
    end
  end

  // The !in_a_q guard keeps an acknowledged request from being recaptured before it is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_a_q <= '0;
      for (int k = 0; k < C; k++) begin
        ch_q[k]   <= WAIT;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < C; k++) begin
        case (ch_q[k])
          WAIT: begin
            if (in_r_s2_q[k] && !in_a_q[k]) begin
              data_q[k] <= in_d[k*N +: N];
              ch_q[k]   <= HELD;
            end
          end
          HELD: begin
            if (join_fire) begin
              in_a_q[k] <= 1'b1;
              ch_q[k]   <= ACKD;
            end
          end
          ACKD: begin
            if (!in_r_s2_q[k]) begin
              in_a_q[k] <= 1'b0;
              ch_q[k]   <= WAIT;
            end
          end
          default: ch_q[k] <= WAIT;
        endcase
      end
    end
  end

  hs_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (join_fire),
    .pop   (pop),
    .din   (join_d),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // The head stays in the buffer until the consumer acknowledges it.
  assign pop = (ost_q == O_REQ) && out_a_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ost_q   <= O_IDLE;
      out_r_q <= 1'b0;
      out_d_q <= '0;
    end else begin
      case (ost_q)
        O_IDLE: begin
          if (!fifo_empty) begin
            out_d_q <= fifo_head;
            ost_q   <= O_SETUP;
          end
        end
        O_SETUP: begin
          out_r_q <= 1'b1;
          ost_q   <= O_REQ;
        end
        O_REQ: begin
          if (out_a_s2_q) begin
            out_r_q <= 1'b0;
            ost_q   <= O_REL;
          end
        end
        O_REL: begin
          if (!out_a_s2_q) ost_q <= O_IDLE;
        end
        default: ost_q <= O_IDLE;
      endcase
    end
  end

  assign in_a  = in_a_q;
  assign out_r = out_r_q;
  assign out_d = out_d_q;

endmodule
